// File: rtl/mem_pkg.sv
// Shared types, constants and the access-fault rule for the memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  // Byte address where RW space begins; everything below is read-only.
  localparam int unsigned ROM_END = 64000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_id_t;

  // A request faults when it is not word aligned, or when it stores into ROM.
  function automatic logic access_fault(input logic [31:0] addr, input logic is_store);
    return (addr[1:0] != 2'b00) || (is_store && (addr < ROM_END));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signal bundle for the shared memory arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold req and payload until their ready pulse.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_fault;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_fault;

  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_write;
  logic [31:0] mem_data_out;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_ready, if_rdata, if_fault, d_ready, d_rdata, d_fault,
           mem_address, mem_data_in, mem_write
  );

  // Environment side: both requesters plus the memory.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_ready, if_rdata, if_fault, d_ready, d_rdata, d_fault,
           mem_address, mem_data_in, mem_write
  );

endinterface

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data, plus the data-grant streak counter.
// Latency: combinational grant; streak updates at the clock edge.
// Backpressure: grants only while arb_en_i is high (arbiter idle).
module mem_arb_priority
  import mem_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    arb_en_i,
  input  logic    if_req_i,
  input  logic    d_req_i,
  output logic    grant_vld_o,
  output req_id_t grant_id_o
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;

  // Data wins a tie unless fetch has already waited through a full streak.
  always_comb begin
    grant_vld_o = arb_en_i && (if_req_i || d_req_i);
    grant_id_o  = REQ_IF;
    if (d_req_i && (!if_req_i || (streak_q != SW'(MAX_STREAK)))) begin
      grant_id_o = REQ_D;
    end
  end

  // Count data grants that bypass a waiting fetch; any idle fetch edge resets it.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i) begin
      streak_d = '0;
    end else if (grant_vld_o && (grant_id_o == REQ_IF)) begin
      streak_d = '0;
    end else if (grant_vld_o && (streak_q != SW'(MAX_STREAK))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences the single memory port between instruction fetch and data load/store.
// Latency: ready MEM_LATENCY+1 cycles after the sampling edge; faulted requests 1 cycle.
// Backpressure: one transaction in flight; requests wait, held, until their ready pulse.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_STREAK  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

  state_t        state_q, state_d;
  req_id_t       id_q, id_d;
  logic          we_q, we_d;
  logic          fault_q, fault_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          grant_vld;
  req_id_t       grant_id;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic          win_we;
  logic          win_fault;

  mem_arb_priority #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clk         (clk),
    .rst_n       (reset),
    .arb_en_i    (state_q == IDLE),
    .if_req_i    (bus.if_req),
    .d_req_i     (bus.d_req),
    .grant_vld_o (grant_vld),
    .grant_id_o  (grant_id)
  );

  // Route the winner's request; the fault is judged on exactly what gets latched.
  always_comb begin
    win_addr  = bus.if_addr;
    win_we    = 1'b0;
    win_wdata = '0;
    if (grant_id == REQ_D) begin
      win_addr  = bus.d_addr;
      win_we    = bus.d_we;
      win_wdata = bus.d_wdata;
    end
    win_fault = access_fault(win_addr, win_we);
  end

  // Next state: grant in IDLE, count down the memory latency, one DONE cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    fault_d    = fault_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d    = grant_id;
          we_d    = win_we;
          wdata_d = win_wdata;
          fault_d = win_fault;
          rdata_d = '0;
          if (win_fault) begin
            state_d = DONE;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = win_addr;
            cnt_d      = CW'(MEM_LATENCY);
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rdata_d = we_q ? '0 : bus.mem_data_out;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      id_q       <= REQ_IF;
      we_q       <= 1'b0;
      fault_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      fault_q    <= fault_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write strobe only in the first ACCESS cycle; decoded from state so reset kills it at once.
  assign bus.mem_address = mem_addr_q;
  assign bus.mem_write   = (state_q == ACCESS) && (cnt_q == CW'(MEM_LATENCY)) && we_q;
  assign bus.mem_data_in = (state_q == ACCESS) ? wdata_q : '0;

  assign bus.if_ready = (state_q == DONE) && (id_q == REQ_IF);
  assign bus.if_rdata = bus.if_ready ? rdata_q : '0;
  assign bus.if_fault = bus.if_ready && fault_q;

  assign bus.d_ready  = (state_q == DONE) && (id_q == REQ_D);
  assign bus.d_rdata  = bus.d_ready ? rdata_q : '0;
  assign bus.d_fault  = bus.d_ready && fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a transaction-level model.
// Latency: checks every ready pulse and write strobe lands on its predicted cycle.
// Backpressure: requesters hold requests until ready, optionally back-to-back.
module tb_mem_arbiter;

  localparam int L     = 1;
  localparam int MAXS  = 4;
  localparam int BOUND = 100;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        fault;
    int          edge_n;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          edge_n;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .MEM_LATENCY (L),
    .MAX_STREAK  (MAXS)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [0:32767];
  logic [31:0] ref_mem [0:32767];
  assign bus.mem_data_out = mem[bus.mem_address[16:2]];

  resp_t exp_q[$];
  wr_t   wr_q[$];
  logic  order_q[$];
  logic  order_on = 1'b0;
  logic  exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: grants whenever the port is free, per the priority/streak rules.
  initial begin : model
    resp_t       e;
    wr_t         w;
    int          free_at;
    int          streak;
    logic        pick_d;
    logic        st;
    logic        flt;
    logic [31:0] a;
    logic [31:0] wd;
    free_at = 0;
    streak  = 0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[64] = 32'hE3A00001; ref_mem[64] = 32'hE3A00001;
    mem[16] = 32'h12345678; ref_mem[16] = 32'h12345678;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        streak  = 0;
        free_at = 0;
        exp_q.delete();
        wr_q.delete();
      end else begin
        if ((cyc >= free_at) && (bus.if_req || bus.d_req)) begin
          pick_d = bus.d_req && !(bus.if_req && (streak == MAXS));
          if (pick_d) begin
            a = bus.d_addr; st = bus.d_we; wd = bus.d_wdata;
          end else begin
            a = bus.if_addr; st = 1'b0; wd = '0;
          end
          flt      = ((a % 4) != 0) || (st && (a < 64000));
          e.is_d   = pick_d;
          e.fault  = flt;
          e.rdata  = (flt || st) ? 32'h0 : ref_mem[a[16:2]];
          e.edge_n = flt ? cyc : cyc + L;
          exp_q.push_back(e);
          if (!flt && st) begin
            w.addr = a; w.data = wd; w.edge_n = cyc;
            wr_q.push_back(w);
            ref_mem[a[16:2]] = wd;
          end
          free_at = cyc + (flt ? 2 : L + 2);
          if (!pick_d) streak = 0;
          else if (bus.if_req && (streak < MAXS)) streak++;
        end
        if (!bus.if_req) streak = 0;
      end
      @(negedge clk);
      if (bus.mem_write) mem[bus.mem_address[16:2]] = bus.mem_data_in;
    end
  end

  // Monitor: every ready pulse and write strobe must match the next prediction.
  resp_t e_m;
  wr_t   w_m;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.if_ready || bus.d_ready) begin
        check("single_ready", {31'b0, bus.if_ready & bus.d_ready}, 32'h0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: got if_ready=%b d_ready=%b, required none (cycle %0d)",
                   bus.if_ready, bus.d_ready, cyc);
        end else begin
          e_m = exp_q.pop_front();
          check("ready_id", {31'b0, bus.d_ready}, {31'b0, e_m.is_d});
          check("ready_cycle", cyc, e_m.edge_n);
          check("rdata", bus.d_ready ? bus.d_rdata : bus.if_rdata, e_m.rdata);
          check("fault", {31'b0, bus.d_ready ? bus.d_fault : bus.if_fault}, {31'b0, e_m.fault});
          if (order_on) order_q.push_back(bus.d_ready);
        end
      end
      if (bus.mem_write) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got write addr=%h data=%h, required no write (cycle %0d)",
                   bus.mem_address, bus.mem_data_in, cyc);
        end else begin
          w_m = wr_q.pop_front();
          check("wr_addr", bus.mem_address, w_m.addr);
          check("wr_data", bus.mem_data_in, w_m.data);
          check("wr_cycle", cyc, w_m.edge_n);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] rd, output logic f);
    int k = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    do begin @(negedge clk); k++; end while (!bus.if_ready && (k < BOUND));
    if (!bus.if_ready) begin
      total++; bad++;
      $display("FAIL if_timeout: got no if_ready in %0d cycles for addr %h, required a ready pulse", k, a);
    end
    rd = bus.if_rdata;
    f  = bus.if_fault;
    @(posedge clk); #1 bus.if_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic f);
    int k = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    do begin @(negedge clk); k++; end while (!bus.d_ready && (k < BOUND));
    if (!bus.d_ready) begin
      total++; bad++;
      $display("FAIL d_timeout: got no d_ready in %0d cycles for addr %h, required a ready pulse", k, a);
    end
    rd = bus.d_rdata;
    f  = bus.d_fault;
    @(posedge clk); #1 bus.d_req = 1'b0;
  endtask

  task automatic fetch_loop(input int n, input bit busy);
    logic [31:0] a, rd;
    logic        f;
    int          k;
    for (int i = 0; i < n; i++) begin
      k = busy ? 0 : int'($urandom_range(0, 3));
      repeat (k) @(posedge clk);
      if (k > 0) #1;
      a = $urandom_range(0, 32'h1FFFF);
      if (busy || ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
      fetch(a, rd, f);
    end
  endtask

  task automatic data_loop(input int n, input bit busy);
    logic [31:0] a, rd;
    logic        we, f;
    int          k;
    for (int i = 0; i < n; i++) begin
      k = busy ? 0 : int'($urandom_range(0, 3));
      repeat (k) @(posedge clk);
      if (k > 0) #1;
      we = busy ? 1'b0 : 1'($urandom_range(0, 1));
      if (!busy && ($urandom_range(0, 2) == 0)) a = $urandom_range(0, 63999);
      else a = $urandom_range(64000, 32'h1FFFF);
      if (busy || ($urandom_range(0, 4) != 0)) a[1:0] = 2'b00;
      dacc(we, a, $urandom, rd, f);
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic        f;
    int          k;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_if_ready", {31'b0, bus.if_ready}, 32'h0);
    check("rst_d_ready", {31'b0, bus.d_ready}, 32'h0);
    check("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fetch(32'h100, rd, f);
    check("fetch_rdata", rd, 32'hE3A00001);
    check("fetch_fault", {31'b0, f}, 32'h0);
    dacc(1'b1, 32'd64000, 32'hDEADBEEF, rd, f);
    check("store_rw_fault", {31'b0, f}, 32'h0);
    dacc(1'b0, 32'd64000, 32'h0, rd, f);
    check("load_back", rd, 32'hDEADBEEF);
    dacc(1'b1, 32'h40, 32'h55555555, rd, f);
    check("rom_store_fault", {31'b0, f}, 32'h1);
    dacc(1'b0, 32'h40, 32'h0, rd, f);
    check("rom_unchanged", rd, 32'h12345678);
    dacc(1'b0, 32'h10002, 32'h0, rd, f);
    check("misaligned_fault", {31'b0, f}, 32'h1);
    check("misaligned_rdata", rd, 32'h0);

    fork
      fetch_loop(40, 1'b0);
      data_loop(60, 1'b0);
    join

    repeat (3) @(posedge clk); #1;
    order_on = 1'b1;
    fork
      fetch_loop(2, 1'b1);
      data_loop(8, 1'b1);
    join
    order_on = 1'b0;
    check("order_len", order_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < order_q.size()) check("grant_order", {31'b0, order_q[i]}, {31'b0, exp_order[i]});
    end

    repeat (2) @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0001_0000; bus.d_wdata = 32'hCAFEF00D;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.mem_write && (k < BOUND));
    check("abort_write_seen", {31'b0, bus.mem_write}, 32'h1);
    #2 rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    check("abort_mem_write", {31'b0, bus.mem_write}, 32'h0);
    check("abort_d_ready", {31'b0, bus.d_ready}, 32'h0);
    check("abort_if_ready", {31'b0, bus.if_ready}, 32'h0);
    check("abort_mem_address", bus.mem_address, 32'h0);
    exp_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h100, rd, f);
    check("post_reset_fetch", rd, 32'hE3A00001);

    repeat (5) @(posedge clk);
    check("pending_resp", exp_q.size(), 32'h0);
    check("pending_write", wr_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
